disp_owner_arbiter: RTL and testbench



---
 rtl/disp_owner_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_disp_owner_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/disp_owner_arbiter.sv
// ---------------------------------------------------------------------------
// disp_owner_arbiter
//
// Purpose:
//   Shares one 8-digit multiplexed 7-segment display between three sources
//   (index 2 = highest priority). A newly granted owner keeps the display for
//   at least HOLD_CYCLES cycles before a higher-priority source may take it,
//   which prevents flicker between sources. The owner may release at any time.
//   The block also scans the digits, decodes BCD to segments and applies the
//   per-digit blank and blink masks. It is the only driver of seg/an.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   req[2:0]     request per source, index 2 = highest priority
//   src_data     source k digits at [32k+31:32k], nibble i -> digit i (0 = rightmost)
//   src_blank    source k blank mask at [8k+7:8k], bit i = 1 forces digit i dark
//   src_blink    source k blink mask at [8k+7:8k], bit i = 1 darkens digit i in blink phase
//   grant[2:0]   one-hot current owner, 0 when idle (registered)
//   owner_valid  OR of grant (registered)
//   seg[6:0]     segments, active low, order {g,f,e,d,c,b,a} (registered)
//   an[7:0]      anodes, active low, at most one low (registered)
//
// Optional feature (macro DISP_GHOST_GUARD_EN):
//   When defined, an is forced to 8'hFF during the first 4 cycles of every
//   digit slot and for 4 cycles after any grant change, to suppress ghosting.
//   Requires SCAN_DIV_BITS >= 3.
// ---------------------------------------------------------------------------
`default_nettype none

module disp_owner_arbiter #(
    parameter int SCAN_DIV_BITS = 16,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int BLINK_BITS    = 25,
    parameter int HOLD_W        = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [95:0] src_data,
    input  logic [23:0] src_blank,
    input  logic [23:0] src_blink,
    output logic [2:0]  grant,
    output logic        owner_valid,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam int SCAN_W = SCAN_DIV_BITS + 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_OPEN   = 2'd2
    } state_t;

    // Index of the highest asserted request (0 when none; callers gate on |r).
    function automatic logic [1:0] highest_idx(input logic [2:0] r);
        logic [1:0] idx;
        if (r[2]) begin
            idx = 2'd2;
        end else if (r[1]) begin
            idx = 2'd1;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // One-hot grant vector for an owner index.
    function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // BCD to active-low segments {g,f,e,d,c,b,a}; non-BCD codes are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t              state_r;
    logic [1:0]          owner_r;
    logic [2:0]          grant_r;
    logic                owner_valid_r;
    logic [HOLD_W-1:0]   hold_r;
    logic [SCAN_W-1:0]   scan_r;
    logic [BLINK_BITS-1:0] blink_r;
    logic [6:0]          seg_r;
    logic [7:0]          an_r;

    logic                owner_req_s;
    logic [2:0]          higher_req_s;
    logic                hold_last_s;
    logic                take_s;
    logic                go_idle_s;
    logic                go_open_s;
    logic                hold_inc_s;

    logic [2:0]          digit_s;
    logic [31:0]         word_s;
    logic [7:0]          blank_mask_s;
    logic [7:0]          blink_mask_s;
    logic [3:0]          nibble_s;
    logic                dark_s;
    logic                guard_s;

    assign hold_last_s = (hold_r == HOLD_W'(HOLD_CYCLES - 1));

    // Current owner's request line and the requests that outrank it.
    always_comb begin
        owner_req_s  = 1'b0;
        higher_req_s = 3'b000;
        case (owner_r)
            2'd0: begin
                owner_req_s  = req[0];
                higher_req_s = req & 3'b110;
            end
            2'd1: begin
                owner_req_s  = req[1];
                higher_req_s = req & 3'b100;
            end
            2'd2: begin
                owner_req_s  = req[2];
                higher_req_s = 3'b000;
            end
            default: begin
                owner_req_s  = 1'b0;
                higher_req_s = 3'b000;
            end
        endcase
    end

    // Arbitration decision for this edge: take a new owner, go idle, open, or count hold.
    always_comb begin
        take_s     = 1'b0;
        go_idle_s  = 1'b0;
        go_open_s  = 1'b0;
        hold_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    take_s = 1'b1;
                end else begin
                    go_idle_s = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Release wins even inside the hold window.
                if (!owner_req_s) begin
                    if (|req) begin
                        take_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end else if (hold_last_s) begin
                    go_open_s = 1'b1;
                end else begin
                    hold_inc_s = 1'b1;
                end
            end
            ST_OPEN: begin
                if (!owner_req_s) begin
                    if (|req) begin
                        take_s = 1'b1;
                    end else begin
                        go_idle_s = 1'b1;
                    end
                end else if (|higher_req_s) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            default: begin
                go_idle_s = 1'b1;
            end
        endcase
    end

    // Ownership FSM with registered grant/owner_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            owner_r       <= 2'd0;
            grant_r       <= 3'b000;
            owner_valid_r <= 1'b0;
            hold_r        <= '0;
        end else if (take_s) begin
            // With the owner released, its bit is low, so highest(req) is the
            // highest remaining requester; when preempting it is the new winner.
            state_r       <= ST_LOCKED;
            owner_r       <= highest_idx(req);
            grant_r       <= idx_to_onehot(highest_idx(req));
            owner_valid_r <= 1'b1;
            hold_r        <= '0;
        end else if (go_idle_s) begin
            state_r       <= ST_IDLE;
            owner_r       <= 2'd0;
            grant_r       <= 3'b000;
            owner_valid_r <= 1'b0;
            hold_r        <= '0;
        end else if (go_open_s) begin
            state_r <= ST_OPEN;
        end else if (hold_inc_s) begin
            hold_r <= hold_r + HOLD_W'(1);
        end else begin
            state_r <= state_r;
        end
    end

    // Free-running scan and blink counters; owner changes do not disturb them.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_r  <= '0;
            blink_r <= '0;
        end else begin
            scan_r  <= scan_r + SCAN_W'(1);
            blink_r <= blink_r + BLINK_BITS'(1);
        end
    end

    assign digit_s = scan_r[SCAN_W-1 -: 3];

    // Select the owning source's digits and masks.
    always_comb begin
        word_s       = 32'h0000_0000;
        blank_mask_s = 8'h00;
        blink_mask_s = 8'h00;
        case (owner_r)
            2'd0: begin
                word_s       = src_data[31:0];
                blank_mask_s = src_blank[7:0];
                blink_mask_s = src_blink[7:0];
            end
            2'd1: begin
                word_s       = src_data[63:32];
                blank_mask_s = src_blank[15:8];
                blink_mask_s = src_blink[15:8];
            end
            2'd2: begin
                word_s       = src_data[95:64];
                blank_mask_s = src_blank[23:16];
                blink_mask_s = src_blink[23:16];
            end
            default: begin
                word_s       = 32'h0000_0000;
                blank_mask_s = 8'h00;
                blink_mask_s = 8'h00;
            end
        endcase
    end

    assign nibble_s = word_s[{digit_s, 2'b00} +: 4];
    assign dark_s   = blank_mask_s[digit_s]
                    | (blink_mask_s[digit_s] & blink_r[BLINK_BITS-1])
                    | (nibble_s > 4'd9);

`ifdef DISP_GHOST_GUARD_EN
    logic [2:0] grant_d_r;
    logic [1:0] guard_cnt_r;

    // Grant-change detector: the edge that sees the change blanks one cycle,
    // the counter extends that to four.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_d_r   <= 3'b000;
            guard_cnt_r <= 2'd0;
        end else if (grant_r != grant_d_r) begin
            grant_d_r   <= grant_r;
            guard_cnt_r <= 2'd3;
        end else if (guard_cnt_r != 2'd0) begin
            grant_d_r   <= grant_r;
            guard_cnt_r <= guard_cnt_r - 2'd1;
        end else begin
            grant_d_r   <= grant_r;
            guard_cnt_r <= 2'd0;
        end
    end

    assign guard_s = (scan_r[SCAN_DIV_BITS-1:0] < SCAN_DIV_BITS'(4))
                   | (guard_cnt_r != 2'd0)
                   | (grant_r != grant_d_r);
`else
    assign guard_s = 1'b0;
`endif

    // Registered display drive, one cycle behind the grant/scan/data it shows.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_r <= 7'h7F;
            an_r  <= 8'hFF;
        end else if (!owner_valid_r) begin
            seg_r <= 7'h7F;
            an_r  <= 8'hFF;
        end else begin
            an_r  <= guard_s ? 8'hFF : ~(8'b0000_0001 << digit_s);
            seg_r <= dark_s ? 7'h7F : seg_decode(nibble_s);
        end
    end

    assign grant       = grant_r;
    assign owner_valid = owner_valid_r;
    assign seg         = seg_r;
    assign an          = an_r;

endmodule

`default_nettype wire

// File: tb/tb_disp_owner_arbiter.sv
`timescale 1ns/1ps

module tb_disp_owner_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] src_data;
    logic [23:0] src_blank;
    logic [23:0] src_blink;
    logic [2:0]  grant;
    logic        owner_valid;
    logic [6:0]  seg;
    logic [7:0]  an;

    int errors;
    int checks;
    int ncyc;   // non-reset edges since the last reset edge

    disp_owner_arbiter #(
        .SCAN_DIV_BITS (2),
        .HOLD_CYCLES   (8),
        .BLINK_BITS    (4),
        .HOLD_W        (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .src_data    (src_data),
        .src_blank   (src_blank),
        .src_blink   (src_blink),
        .grant       (grant),
        .owner_valid (owner_valid),
        .seg         (seg),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode from the segment table.
    function automatic logic [6:0] ref_seg(input logic [3:0] n, input logic bl,
                                           input logic bk, input logic ph);
        logic [6:0] s;
        if (bl || (bk && ph) || n > 4'd9) begin
            s = 7'h7F;
        end else begin
            case (n)
                4'd0: s = 7'h40; 4'd1: s = 7'h79; 4'd2: s = 7'h24; 4'd3: s = 7'h30;
                4'd4: s = 7'h19; 4'd5: s = 7'h12; 4'd6: s = 7'h02; 4'd7: s = 7'h78;
                4'd8: s = 7'h00; 4'd9: s = 7'h10;
                default: s = 7'h7F;
            endcase
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) ncyc = 0;
        else ncyc = ncyc + 1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        src_data = 96'h0; src_blank = 24'h0; src_blink = 24'h0;
        req = 3'b111;
        reset = 1'b1;
        step();
        step();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected %b", grant, 3'b000); end
        checks++; if (owner_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", owner_valid); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected FF", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7F", seg); end
        reset = 1'b0;
        step();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL reset_first_grant: got %b expected 100", grant); end
        checks++; if (owner_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", owner_valid); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_first_an: got %h expected FF", an); end
        step();
        checks++; if (an !== 8'hFE) begin errors++; $display("FAIL reset_digit0_an: got %h expected FE", an); end
        checks++; if (seg !== 7'h40) begin errors++; $display("FAIL reset_digit0_seg: got %h expected 40", seg); end
    endtask

    task automatic test_lock();
        req = 3'b001;
        reset_pulse();
        // Edges e0..e8 keep owner 0 (hold window then OPEN), e9 hands over.
        for (int i = 0; i < 9; i++) begin
            if (i == 2) req = 3'b011;
            step();
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lock_hold[%0d]: got %b expected 001", i, grant); end
        end
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL lock_preempt: got %b expected 010", grant); end
        // Owner release while still locked is honoured at once.
        req = 3'b000;
        reset_pulse();
        req = 3'b001;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lock_take0: got %b expected 001", grant); end
        req = 3'b011;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL lock_ignore_higher: got %b expected 001", grant); end
        req = 3'b010;
        step();
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL lock_release_switch: got %b expected 010", grant); end
    endtask

    task automatic test_release();
        req = 3'b100;
        reset_pulse();
        step();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rel_take2: got %b expected 100", grant); end
        req = 3'b000;
        step();
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rel_idle_grant: got %b expected 000", grant); end
        checks++; if (owner_valid !== 1'b0) begin errors++; $display("FAIL rel_idle_valid: got %b expected 0", owner_valid); end
        step();
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL rel_idle_an: got %h expected FF", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rel_idle_seg: got %h expected 7F", seg); end
        // Reach OPEN with owner 2, then a lower request must not preempt.
        req = 3'b100;
        for (int i = 0; i < 9; i++) step();
        req = 3'b101;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rel_open_lower[%0d]: got %b expected 100", i, grant); end
        end
        req = 3'b001;
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rel_to_lower: got %b expected 001", grant); end
        // Owner drops while a higher source appears: higher wins immediately.
        req = 3'b100;
        step();
        checks++; if (grant !== 3'b100) begin errors++; $display("FAIL rel_simultaneous: got %b expected 100", grant); end
    endtask

    task automatic test_scan();
        logic [31:0] w;
        int k, d;
        src_data  = {32'h9999_9999, 32'h8888_8888, 32'h7654_3210};
        src_blank = 24'h0;
        src_blink = 24'h0;
        req = 3'b001;
        reset_pulse();
        step();
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL scan_grant: got %b expected 001", grant); end
        checks++; if (an !== 8'hFF) begin errors++; $display("FAIL scan_first_an: got %h expected FF", an); end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) src_data[31:0] = 32'h7654_321A;
            w = src_data[31:0];
            for (int i = 0; i < 32; i++) begin
                step();
                k = ncyc - 1;
                d = (k >> 2) & 7;
                checks++;
                if (an !== ~(8'b0000_0001 << d)) begin
                    errors++; $display("FAIL scan_an[%0d]: got %h expected %h", k, an, ~(8'b0000_0001 << d));
                end
                checks++;
                if (seg !== ref_seg(w[4*d +: 4], 1'b0, 1'b0, 1'b0)) begin
                    errors++; $display("FAIL scan_seg[%0d]: got %h expected %h", k, seg, ref_seg(w[4*d +: 4], 1'b0, 1'b0, 1'b0));
                end
            end
        end
    endtask

    task automatic test_blink_blank();
        logic [31:0] w;
        logic [7:0]  bl, bk;
        logic [6:0]  e;
        int k, d;
        src_data  = {32'h9999_9999, 32'h8888_8888, 32'h7654_3210};
        src_blank = 24'h000002;
        src_blink = 24'h000005;
        req = 3'b001;
        reset_pulse();
        step();
        w  = src_data[31:0];
        bl = src_blank[7:0];
        bk = src_blink[7:0];
        for (int i = 0; i < 64; i++) begin
            step();
            k = ncyc - 1;
            d = (k >> 2) & 7;
            e = ref_seg(w[4*d +: 4], bl[d], bk[d], ((k >> 3) & 1) == 1);
            checks++;
            if (seg !== e) begin
                errors++; $display("FAIL blink_seg[%0d]: got %h expected %h", k, seg, e);
            end
            checks++;
            if (an !== ~(8'b0000_0001 << d)) begin
                errors++; $display("FAIL blink_an[%0d]: got %h expected %h", k, an, ~(8'b0000_0001 << d));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ncyc = 0;
        reset = 1'b1;
        req = 3'b000;
        src_data = 96'h0;
        src_blank = 24'h0;
        src_blink = 24'h0;
        test_reset();
        test_lock();
        test_release();
        test_scan();
        test_blink_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
